pattern_monitor: RTL and testbench

- Downstream consumer of the 2-bit state stream produced by the sequential test top (state[1:0] sampled per step).
- Detects a programmable sequence of 2-bit symbols over a sliding window, with overlapping matches allowed.
- Counts matches and reports each one on a ready/valid event port.
- Serves as a stateful property monitor for the decision-procedure examples.

---
 rtl/pattern_monitor_pkg.sv | 15 +
 rtl/pattern_monitor_sat_counter.sv | 29 ++
 rtl/pattern_monitor.sv | 105 ++++++++++
 tb/tb_pattern_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_monitor_pkg.sv
// rtl/pattern_monitor_pkg.sv - shared symbol, FSM state and default pattern for pattern_monitor
package pattern_monitor_pkg;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Symbols 0,1,3,2 with symbol 0 in the low bits.
  localparam logic [7:0] DEFAULT_PATTERN = 8'hB4;

endpackage

// File: rtl/pattern_monitor_sat_counter.sv
// rtl/pattern_monitor_sat_counter.sv - saturating up-counter with sticky saturation flag
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX      = '1;
  localparam logic [W-1:0] MAX_LESS = MAX - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
      if (cnt == MAX_LESS) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/pattern_monitor.sv
// rtl/pattern_monitor.sv - sliding-window 2-bit symbol pattern detector with match count and event port
// Optional don't-care mask input enabled by PATTERN_MONITOR_MASK_EN.
module pattern_monitor
  import pattern_monitor_pkg::*;
#(
  parameter int                   PAT_LEN = 4,
  parameter int                   CNT_W   = 8,
  parameter logic [2*PAT_LEN-1:0] PATTERN = (2*PAT_LEN)'(DEFAULT_PATTERN)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  input  sym_t             in_sym,
  output logic             in_ready,
  input  logic             clear,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             sat,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_idx
`ifdef PATTERN_MONITOR_MASK_EN
  ,
  input  logic [2*PAT_LEN-1:0] pat_mask
`endif
);

  localparam int             WW        = 2 * PAT_LEN;
  localparam int             FW        = 4;
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_LEN);
  localparam logic [FW-1:0]  FILL_LAST = FW'(PAT_LEN - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WW-1:0]   r_win;
  logic [WW-1:0]   w_win_nxt;
  logic [WW-1:0]   w_mask;
  logic [FW-1:0]   r_fill;
  logic            r_match;
  logic            w_acc;
  logic            w_full_nxt;
  logic            w_hit;

`ifdef PATTERN_MONITOR_MASK_EN
  assign w_mask = pat_mask;
`else
  assign w_mask = '1;
`endif

  assign evt_valid  = (r_state == HOLD);
  assign in_ready   = ~evt_valid | evt_ready;
  assign w_acc      = in_valid & in_ready & ~clear;
  // Newest symbol enters at the top; the oldest falls off bits [1:0].
  assign w_win_nxt  = {in_sym, r_win[WW-1:2]};
  assign w_full_nxt = (r_fill >= FILL_LAST);
  assign w_hit      = w_acc & w_full_nxt & (((w_win_nxt ^ PATTERN) & w_mask) == '0);

  assign match   = r_match;
  assign evt_idx = match_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= FILL;
      r_win   <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_match <= w_hit;
      if (clear) begin
        r_win  <= '0;
        r_fill <= '0;
      end else if (w_acc) begin
        r_win <= w_win_nxt;
        if (r_fill != FILL_FULL) r_fill <= r_fill + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = FILL;
    end else begin
      case (r_state)
        FILL:    if (w_acc && w_full_nxt) w_state_nxt = w_hit ? HOLD : ARMED;
        ARMED:   if (w_hit) w_state_nxt = HOLD;
        HOLD:    if (evt_ready) w_state_nxt = w_hit ? HOLD : ARMED;
        default: w_state_nxt = FILL;
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (CLK),
    .rst_n(RST_N),
    .inc  (w_hit),
    .clr  (clear),
    .cnt  (match_cnt),
    .sat  (sat)
  );

endmodule

// File: tb/tb_pattern_monitor.sv
// tb/tb_pattern_monitor.sv - self-checking bench: default instance and PATTERN=0000/CNT_W=2 instance
module tb_pattern_monitor;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_sym = 2'd0;
  logic       clear = 1'b0;
  logic       evt_ready = 1'b0;

  always #5 CLK = ~CLK;

  logic       a_rdy, a_match, a_sat, a_ev;
  logic [7:0] a_cnt, a_idx;
  logic       b_rdy, b_match, b_sat, b_ev;
  logic [1:0] b_cnt, b_idx;

  pattern_monitor u_a (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_sym(in_sym), .in_ready(a_rdy),
    .clear(clear), .match(a_match), .match_cnt(a_cnt), .sat(a_sat), .evt_valid(a_ev),
    .evt_ready(evt_ready), .evt_idx(a_idx)
`ifdef PATTERN_MONITOR_MASK_EN
    , .pat_mask(8'hFF)
`endif
  );

  pattern_monitor #(.PAT_LEN(4), .CNT_W(2), .PATTERN(8'h00)) u_b (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_sym(in_sym), .in_ready(b_rdy),
    .clear(clear), .match(b_match), .match_cnt(b_cnt), .sat(b_sat), .evt_valid(b_ev),
    .evt_ready(evt_ready), .evt_idx(b_idx)
`ifdef PATTERN_MONITOR_MASK_EN
    , .pat_mask(8'hFF)
`endif
  );

  logic       o_rdy [2];
  logic       o_match [2];
  logic       o_sat [2];
  logic       o_ev [2];
  logic [7:0] o_cnt [2];
  logic [7:0] o_idx [2];
  assign o_rdy[0] = a_rdy;   assign o_rdy[1] = b_rdy;
  assign o_match[0] = a_match; assign o_match[1] = b_match;
  assign o_sat[0] = a_sat;   assign o_sat[1] = b_sat;
  assign o_ev[0] = a_ev;     assign o_ev[1] = b_ev;
  assign o_cnt[0] = a_cnt;   assign o_cnt[1] = {6'd0, b_cnt};
  assign o_idx[0] = a_idx;   assign o_idx[1] = {6'd0, b_idx};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: symbol history, counts and pending-event flag per instance.
  int pat_sym [2][4] = '{'{0, 1, 3, 2}, '{0, 0, 0, 0}};
  int cmax [2] = '{255, 3};
  int m_last [2][4];
  int m_n [2];
  int m_cnt [2];
  bit m_sat [2];
  bit m_pend [2];
  bit e_match [2];
  bit e_rdy [2];
  logic o_rdy_pre [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) m_last[d][i] = 0;
      m_n[d] = 0; m_cnt[d] = 0; m_sat[d] = 0; m_pend[d] = 0; e_match[d] = 0;
    end
  endtask

  task automatic step(input bit v, input int s, input bit rdy, input bit clr);
    bit hit;
    bit all_eq;
    in_valid = v; in_sym = 2'(s); evt_ready = rdy; clear = clr;
    #1;
    for (int d = 0; d < 2; d++) begin
      e_rdy[d] = !m_pend[d] || rdy;
      o_rdy_pre[d] = o_rdy[d];
      hit = 0;
      if (clr) begin
        for (int i = 0; i < 4; i++) m_last[d][i] = 0;
        m_n[d] = 0; m_cnt[d] = 0; m_sat[d] = 0; m_pend[d] = 0;
      end else begin
        if (m_pend[d] && rdy) m_pend[d] = 0;
        if (v && e_rdy[d]) begin
          for (int i = 0; i < 3; i++) m_last[d][i] = m_last[d][i+1];
          m_last[d][3] = s;
          m_n[d]++;
          all_eq = 1;
          for (int i = 0; i < 4; i++) if (m_last[d][i] != pat_sym[d][i]) all_eq = 0;
          hit = (m_n[d] >= 4) && all_eq;
        end
        if (hit) begin
          if (m_cnt[d] < cmax[d]) m_cnt[d]++;
          if (m_cnt[d] == cmax[d]) m_sat[d] = 1;
          m_pend[d] = 1;
        end
      end
      e_match[d] = hit;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; in_valid = 1'b1;
    @(posedge CLK); #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (o_rdy[d] !== 1'b1) begin n_bad++; $display("FAIL reset in_ready dut%0d: got %b want 1", d, o_rdy[d]); end
      n_cmp++; if ({o_match[d], o_sat[d], o_ev[d]} !== 3'b000) begin n_bad++; $display("FAIL reset flags dut%0d: got %b want 000", d, {o_match[d], o_sat[d], o_ev[d]}); end
      n_cmp++; if (o_cnt[d] !== 8'd0 || o_idx[d] !== 8'd0) begin n_bad++; $display("FAIL reset count dut%0d: got %0d/%0d want 0/0", d, o_cnt[d], o_idx[d]); end
    end
    RST_N = 1'b1; in_valid = 1'b0;
    model_reset();
    step(0, 0, 0, 0);
  endtask

  task automatic test_basic();
    int seq [4] = '{0, 1, 3, 2};
    for (int k = 0; k < 5; k++) begin
      step(k < 4, (k < 4) ? seq[k] : 0, 1, 0);
      for (int d = 0; d < 2; d++) begin
        n_cmp++; if (o_match[d] !== e_match[d]) begin n_bad++; $display("FAIL basic match dut%0d k%0d: got %b want %b", d, k, o_match[d], e_match[d]); end
        n_cmp++; if (o_ev[d] !== m_pend[d]) begin n_bad++; $display("FAIL basic evt_valid dut%0d k%0d: got %b want %b", d, k, o_ev[d], m_pend[d]); end
        n_cmp++; if (o_cnt[d] !== 8'(m_cnt[d])) begin n_bad++; $display("FAIL basic cnt dut%0d k%0d: got %0d want %0d", d, k, o_cnt[d], m_cnt[d]); end
      end
      if (k == 3) begin
        n_cmp++; if ({a_match, a_ev, a_idx} !== {1'b1, 1'b1, 8'd1}) begin n_bad++; $display("FAIL basic 4th accept: got m%b v%b idx%0d want m1 v1 idx1", a_match, a_ev, a_idx); end
      end
    end
  endtask

  task automatic test_overlap_sat();
    int want [5] = '{1, 2, 3, 3, 3};
    step(0, 0, 1, 1);
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 1, 0);
      n_cmp++; if (b_match !== e_match[1]) begin n_bad++; $display("FAIL overlap match k%0d: got %b want %b", k, b_match, e_match[1]); end
      n_cmp++; if ({b_sat, b_cnt} !== {m_sat[1], 2'(m_cnt[1])}) begin n_bad++; $display("FAIL overlap sat/cnt k%0d: got %b/%0d want %b/%0d", k, b_sat, b_cnt, m_sat[1], m_cnt[1]); end
      if (k >= 3) begin
        n_cmp++; if (b_cnt !== 2'(want[k-3])) begin n_bad++; $display("FAIL sat sequence k%0d: got %0d want %0d", k, b_cnt, want[k-3]); end
      end
    end
    step(0, 0, 1, 1);
    n_cmp++; if ({b_cnt, b_sat, b_match} !== 4'b0000) begin n_bad++; $display("FAIL sat clear: got cnt%0d sat%b m%b want 0 0 0", b_cnt, b_sat, b_match); end
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 1, 0);
      n_cmp++; if (b_match !== (k == 3)) begin n_bad++; $display("FAIL refill k%0d: got %b want %b", k, b_match, (k == 3)); end
    end
  endtask

  task automatic test_backpressure();
    int seq [4] = '{0, 1, 3, 2};
    step(0, 0, 1, 1);
    for (int k = 0; k < 4; k++) step(1, seq[k], 0, 0);
    n_cmp++; if (a_ev !== 1'b1 || a_rdy !== 1'b0) begin n_bad++; $display("FAIL bp hold entry: got v%b r%b want v1 r0", a_ev, a_rdy); end
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 0);
      n_cmp++; if (o_rdy_pre[0] !== e_rdy[0]) begin n_bad++; $display("FAIL bp in_ready k%0d: got %b want %b", k, o_rdy_pre[0], e_rdy[0]); end
      n_cmp++; if (a_idx !== 8'(m_cnt[0]) || a_ev !== 1'b1) begin n_bad++; $display("FAIL bp idx k%0d: got %0d v%b want %0d v1", k, a_idx, a_ev, m_cnt[0]); end
    end
    step(1, 1, 1, 0);
    n_cmp++; if (o_rdy_pre[0] !== 1'b1 || a_ev !== 1'b0) begin n_bad++; $display("FAIL bp release: got r%b v%b want r1 v0", o_rdy_pre[0], a_ev); end
    // Window should now hold 1,3,2,1; finishing 0,1,3,2 matches only on the last symbol.
    for (int k = 0; k < 4; k++) begin
      step(1, seq[k], 1, 0);
      n_cmp++; if (a_match !== e_match[0]) begin n_bad++; $display("FAIL bp window k%0d: got %b want %b", k, a_match, e_match[0]); end
    end
  endtask

  task automatic test_clear_vs_accept();
    int seq [4] = '{0, 1, 3, 2};
    int tail [3] = '{1, 3, 2};
    step(0, 0, 1, 1);
    for (int k = 0; k < 4; k++) step(1, seq[k], 0, 0);
    step(1, 0, 0, 1);
    n_cmp++; if ({a_ev, a_match, a_cnt} !== {1'b0, 1'b0, 8'd0}) begin n_bad++; $display("FAIL clear hold: got v%b m%b cnt%0d want 0 0 0", a_ev, a_match, a_cnt); end
    for (int k = 0; k < 3; k++) begin
      step(1, tail[k], 1, 0);
      n_cmp++; if (a_match !== 1'b0) begin n_bad++; $display("FAIL clear fill k%0d: got %b want 0", k, a_match); end
    end
  endtask

  task automatic test_async_reset();
    int seq [4] = '{0, 1, 3, 2};
    step(0, 0, 1, 1);
    for (int k = 0; k < 4; k++) step(1, seq[k], 0, 0);
    in_valid = 1'b1; in_sym = 2'd2;
    #3; RST_N = 1'b0; #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if ({o_rdy[d], o_match[d], o_sat[d], o_ev[d]} !== 4'b1000) begin n_bad++; $display("FAIL async reset dut%0d: got %b want 1000", d, {o_rdy[d], o_match[d], o_sat[d], o_ev[d]}); end
      n_cmp++; if (o_cnt[d] !== 8'd0) begin n_bad++; $display("FAIL async reset cnt dut%0d: got %0d want 0", d, o_cnt[d]); end
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    int s;
    int r;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 3);
      s = (r == 0) ? 0 : (r == 1) ? pat_sym[0][m_n[0] % 4] : $urandom_range(0, 3);
      step($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      for (int d = 0; d < 2; d++) begin
        n_cmp++; if (o_rdy_pre[d] !== e_rdy[d]) begin n_bad++; $display("FAIL rnd in_ready dut%0d c%0d: got %b want %b", d, c, o_rdy_pre[d], e_rdy[d]); end
        n_cmp++; if (o_match[d] !== e_match[d]) begin n_bad++; $display("FAIL rnd match dut%0d c%0d: got %b want %b", d, c, o_match[d], e_match[d]); end
        n_cmp++; if (o_cnt[d] !== 8'(m_cnt[d]) || o_sat[d] !== m_sat[d]) begin n_bad++; $display("FAIL rnd cnt dut%0d c%0d: got %0d/%b want %0d/%b", d, c, o_cnt[d], o_sat[d], m_cnt[d], m_sat[d]); end
        n_cmp++; if (o_ev[d] !== m_pend[d]) begin n_bad++; $display("FAIL rnd evt_valid dut%0d c%0d: got %b want %b", d, c, o_ev[d], m_pend[d]); end
        if (m_pend[d]) begin
          n_cmp++; if (o_idx[d] !== 8'(m_cnt[d])) begin n_bad++; $display("FAIL rnd evt_idx dut%0d c%0d: got %0d want %0d", d, c, o_idx[d], m_cnt[d]); end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overlap_sat();
    test_backpressure();
    test_clear_vs_accept();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
